// File: rtl/actuator_coeff_sched_if.sv
// Bus between the HWPE control slave / engine and the coefficient scheduler.
// The slave modport is the scheduler's view; the master modport is the driver's view.
interface actuator_coeff_sched_if #(
  parameter int N_COEFF = 6,
  parameter int DATA_W  = 32,
  parameter int GEN_W   = 8
);
  localparam int ADDR_W = $clog2(N_COEFF);

  logic                      clear_i;
  logic                      wr_en_i;
  logic [ADDR_W-1:0]         wr_addr_i;
  logic [DATA_W-1:0]         wr_data_i;
  logic                      commit_i;
  logic                      engine_busy_i;
  logic                      boundary_i;
  logic [N_COEFF*DATA_W-1:0] coeff_o;
  logic                      coeff_valid_o;
  logic                      hold_o;
  logic                      pending_o;
  logic                      swap_done_o;
  logic                      wr_err_o;
  logic [GEN_W-1:0]          gen_o;

  modport slave (
    input  clear_i, wr_en_i, wr_addr_i, wr_data_i, commit_i, engine_busy_i, boundary_i,
    output coeff_o, coeff_valid_o, hold_o, pending_o, swap_done_o, wr_err_o, gen_o
  );

  modport master (
    output clear_i, wr_en_i, wr_addr_i, wr_data_i, commit_i, engine_busy_i, boundary_i,
    input  coeff_o, coeff_valid_o, hold_o, pending_o, swap_done_o, wr_err_o, gen_o
  );
endinterface

// File: rtl/actuator_coeff_sched.sv
// Double-buffered coefficient scheduler for the actuator polynomial engine.
// Software fills a shadow bank word by word and requests a commit; the active bank
// is replaced only while the engine is idle or on a vector boundary, so a vector is
// always processed with one consistent coefficient set.
module actuator_coeff_sched #(
  parameter int N_COEFF = 6,
  parameter int DATA_W  = 32,
  parameter int GEN_W   = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,   // active-high synchronous reset
  actuator_coeff_sched_if.slave bus
);

  localparam int ADDR_W = $clog2(N_COEFF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_e;

  state_e                    state_q;
  logic                      pending_q;
  logic                      hold_q;
  logic                      swap_done_q;

  logic [DATA_W-1:0]         shadow_q [N_COEFF];
  logic [DATA_W-1:0]         shadow_d [N_COEFF];
  logic [DATA_W-1:0]         active_q [N_COEFF];
  logic [GEN_W-1:0]          gen_q;
  logic                      valid_q;
  logic                      wr_err_q;
  logic                      wr_oob;
  logic [N_COEFF*DATA_W-1:0] coeff_flat;

  // Address beyond the last coefficient word: write is dropped and flagged.
  assign wr_oob = bus.wr_en_i &&
                  ({1'b0, bus.wr_addr_i} >= (ADDR_W + 1)'(N_COEFF));

  // Shadow bank next state: one word may be overwritten per cycle, in any state.
  always_comb begin
    for (int k = 0; k < N_COEFF; k++) begin
      shadow_d[k] = shadow_q[k];
      if (bus.wr_en_i && (bus.wr_addr_i == ADDR_W'(k))) begin
        shadow_d[k] = bus.wr_data_i;
      end
    end
  end

  // Commit scheduler: decides when the shadow bank may replace the active bank.
  // Outputs are registered alongside the state so they follow it exactly.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      hold_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else if (bus.clear_i) begin
      // Soft clear drops any outstanding commit; banks and counters are untouched.
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      hold_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.commit_i && !bus.engine_busy_i) begin
            state_q     <= SWAP;
            pending_q   <= 1'b1;
            hold_q      <= 1'b1;
            swap_done_q <= 1'b1;
          end else if (bus.commit_i) begin
            state_q     <= PENDING;
            pending_q   <= 1'b1;
            hold_q      <= 1'b0;
            swap_done_q <= 1'b0;
          end else begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            hold_q      <= 1'b0;
            swap_done_q <= 1'b0;
          end
        end
        PENDING: begin
          // Further commits while waiting collapse into the one already queued.
          if (bus.boundary_i || !bus.engine_busy_i) begin
            state_q     <= SWAP;
            pending_q   <= 1'b1;
            hold_q      <= 1'b1;
            swap_done_q <= 1'b1;
          end else begin
            state_q     <= PENDING;
            pending_q   <= 1'b1;
            hold_q      <= 1'b0;
            swap_done_q <= 1'b0;
          end
        end
        SWAP: begin
          // A commit arriving during the swap targets data written after it,
          // so it is queued and re-evaluated against the engine state.
          if (bus.commit_i) begin
            state_q     <= PENDING;
            pending_q   <= 1'b1;
          end else begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
          end
          hold_q      <= 1'b0;
          swap_done_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          pending_q   <= 1'b0;
          hold_q      <= 1'b0;
          swap_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient banks, swap generation counter and write-error flag.
  // The copy reads shadow_q, so a write landing in the SWAP cycle itself is kept
  // for the next commit. A swap already in its SWAP cycle completes even if a
  // soft clear arrives in that cycle: hold_o/swap_done_o have already been shown.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < N_COEFF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      gen_q    <= '0;
      valid_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_COEFF; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
      wr_err_q <= wr_oob;
      if (state_q == SWAP) begin
        for (int k = 0; k < N_COEFF; k++) begin
          active_q[k] <= shadow_q[k];
        end
        gen_q   <= gen_q + GEN_W'(1);
        valid_q <= 1'b1;
      end
    end
  end

  // Flatten the active bank onto the engine coefficient bus.
  always_comb begin
    coeff_flat = '0;
    for (int k = 0; k < N_COEFF; k++) begin
      coeff_flat[k*DATA_W +: DATA_W] = active_q[k];
    end
  end

  assign bus.coeff_o       = coeff_flat;
  assign bus.coeff_valid_o = valid_q;
  assign bus.hold_o        = hold_q;
  assign bus.pending_o     = pending_q;
  assign bus.swap_done_o   = swap_done_q;
  assign bus.wr_err_o      = wr_err_q;
  assign bus.gen_o         = gen_q;

endmodule
